sample_capture: RTL and testbench

Writer side of the oscilloscope sample buffer. It takes the 12-bit ADC sample stream, decimates it and waits for an edge trigger (or an auto-timeout). It then records 256 consecutive accepted samples into a back bank of a double buffer. At the next vertical-blank start it swaps that bank to the front, so the display pipeline always reads a complete, tear-free `data_display [0:255]` frame.

---
 rtl/sample_capture_pkg.sv | 11 +
 rtl/sample_capture_if.sv | 27 ++
 rtl/sample_capture_trigger_detect.sv | 51 +++++
 rtl/sample_capture.sv | 147 ++++++++++++++
 tb/tb_sample_capture.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/sample_capture_pkg.sv
// Shared constants and types for the oscilloscope sample capture writer.
package sample_capture_pkg;

  localparam int SAMPLES  = 256;
  localparam int SAMPLE_W = 12;

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} capture_state_t;

  typedef logic [11:0] sample_t;

endpackage

// File: rtl/sample_capture_if.sv
// ADC sample stream, trigger controls, blanking input and front-frame outputs.
interface sample_capture_if;
  import sample_capture_pkg::*;

  logic       sample_valid;
  sample_t    sample;
  sample_t    trig_level;
  logic       trig_falling;
  logic       auto_mode;
  logic [7:0] decim;
  logic       freeze;
  logic       vblnk;
  sample_t    data_display [0:SAMPLES-1];
  logic       frame_ready;
  logic       triggered;

  modport master (
    output sample_valid, sample, trig_level, trig_falling, auto_mode, decim, freeze, vblnk,
    input  data_display, frame_ready, triggered
  );

  modport slave (
    input  sample_valid, sample, trig_level, trig_falling, auto_mode, decim, freeze, vblnk,
    output data_display, frame_ready, triggered
  );

endinterface

// File: rtl/sample_capture_trigger_detect.sv
// Decimator plus edge trigger: flags accepted samples and level crossings between
// consecutive accepted samples.
module trigger_detect
  import sample_capture_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  sample_t    sample,
  input  sample_t    trig_level,
  input  logic       trig_falling,
  input  logic [7:0] decim,
  input  logic       clr_prev,
  output logic       accept,
  output logic       trig_hit
);

  logic [7:0] dcnt_reg;
  sample_t    prev_reg;
  logic       prev_ok_reg;
  logic       above_prev;
  logic       above_cur;

  assign accept     = sample_valid && (dcnt_reg == 8'd0);
  assign above_prev = (prev_reg >= trig_level);
  assign above_cur  = (sample >= trig_level);
  assign trig_hit   = accept && prev_ok_reg &&
                      (trig_falling ? (above_prev && !above_cur) : (!above_prev && above_cur));

  always_ff @(posedge clk) begin
    if (!rst) begin
      dcnt_reg    <= 8'd0;
      prev_reg    <= '0;
      prev_ok_reg <= 1'b0;
    end else begin
      if (sample_valid) begin
        dcnt_reg <= accept ? decim : dcnt_reg - 8'd1;
      end
      if (accept) begin
        prev_reg <= sample;
      end
      // A fresh arm must not compare against a sample from the previous frame.
      if (clr_prev) begin
        prev_ok_reg <= 1'b0;
      end else if (accept) begin
        prev_ok_reg <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sample_capture.sv
// Capture FSM and double-buffered sample banks; the back bank is filled after a
// trigger and swapped to the front on the next vertical-blank start.
module sample_capture
  import sample_capture_pkg::*;
#(
  parameter int SAMPLES      = sample_capture_pkg::SAMPLES,
  parameter int SAMPLE_W     = sample_capture_pkg::SAMPLE_W,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic           clk,
  input  logic           rst,
  sample_capture_if.slave io
);

  localparam int IDX_W  = $clog2(SAMPLES);
  localparam int TCNT_W = $clog2(AUTO_TIMEOUT);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(SAMPLES - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(AUTO_TIMEOUT - 1);

  capture_state_t     state_reg, state_next;
  logic [IDX_W-1:0]   widx_reg, widx_next;
  logic [TCNT_W-1:0]  tcnt_reg, tcnt_next;
  logic               kind_reg, kind_next;
  logic               front_sel_reg;
  logic               triggered_reg;
  logic               frame_ready_reg;
  logic               vblnk_q_reg;
  logic [SAMPLE_W-1:0] bank_reg [0:1][0:SAMPLES-1];

  logic               accept;
  logic               trig_hit;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic               swap;
  logic               clr_prev;

  trigger_detect u_trigger_detect (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (io.sample_valid),
    .sample       (io.sample),
    .trig_level   (io.trig_level),
    .trig_falling (io.trig_falling),
    .decim        (io.decim),
    .clr_prev     (clr_prev),
    .accept       (accept),
    .trig_hit     (trig_hit)
  );

  always_comb begin
    state_next = state_reg;
    widx_next  = widx_reg;
    tcnt_next  = tcnt_reg;
    kind_next  = kind_reg;
    wr_en      = 1'b0;
    wr_idx     = widx_reg;
    swap       = 1'b0;
    clr_prev   = 1'b0;
    case (state_reg)
      IDLE: begin
        state_next = WAIT_TRIG;
        clr_prev   = 1'b1;
        tcnt_next  = '0;
        widx_next  = '0;
      end
      WAIT_TRIG: begin
        if (accept) begin
          // A real trigger wins over a simultaneous timeout.
          if (trig_hit || (io.auto_mode && tcnt_reg == TCNT_LAST)) begin
            wr_en      = 1'b1;
            wr_idx     = '0;
            widx_next  = IDX_W'(1);
            kind_next  = trig_hit;
            state_next = CAPTURE;
          end else begin
            tcnt_next = tcnt_reg + TCNT_W'(1);
          end
        end
      end
      CAPTURE: begin
        if (accept) begin
          wr_en     = 1'b1;
          widx_next = widx_reg + IDX_W'(1);
          if (widx_reg == LAST_IDX) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (io.vblnk && !vblnk_q_reg && !io.freeze) begin
          swap       = 1'b1;
          clr_prev   = 1'b1;
          tcnt_next  = '0;
          state_next = WAIT_TRIG;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= IDLE;
      widx_reg        <= '0;
      tcnt_reg        <= '0;
      kind_reg        <= 1'b0;
      front_sel_reg   <= 1'b0;
      triggered_reg   <= 1'b0;
      frame_ready_reg <= 1'b0;
      vblnk_q_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      widx_reg        <= widx_next;
      tcnt_reg        <= tcnt_next;
      kind_reg        <= kind_next;
      frame_ready_reg <= swap;
      vblnk_q_reg     <= io.vblnk;
      if (swap) begin
        front_sel_reg <= ~front_sel_reg;
        triggered_reg <= kind_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < SAMPLES; i++) begin
          bank_reg[b][i] <= '0;
        end
      end
    end else if (wr_en) begin
      bank_reg[~front_sel_reg][wr_idx] <= io.sample;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < SAMPLES; gi++) begin : g_display
      assign io.data_display[gi] = bank_reg[front_sel_reg][gi];
    end
  endgenerate

  assign io.frame_ready = frame_ready_reg;
  assign io.triggered   = triggered_reg;

endmodule

// File: tb/tb_sample_capture.sv
// Scoreboard bench for sample_capture: captured samples are queued as they are driven
// and compared against the front frame whenever a bank swap is reported.
module tb_sample_capture;
  import sample_capture_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sample_capture_if io ();

  sample_capture #(.AUTO_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  int      n_tests  = 0;
  int      n_fail   = 0;
  int      fr_count = 0;
  int      nz;
  logic    fr_prev  = 1'b0;
  logic    exp_t;
  sample_t exp_q[$];
  logic    exp_trig_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input int v, input bit push);
    io.sample       = 12'(v);
    io.sample_valid = 1'b1;
    if (push) exp_q.push_back(12'(v));
    @(posedge clk);
    #1;
    io.sample_valid = 1'b0;
  endtask

  task automatic blank_pulse();
    io.vblnk = 1'b1;
    tick(1);
    io.vblnk = 1'b0;
    tick(2);
  endtask

  task automatic expect_frames(input int n);
    for (int i = 0; i < 20 && fr_count < n; i++) tick(1);
    check_val("frame_count", fr_count, n);
  endtask

  task automatic check_state(input string tag, input capture_state_t s);
    check_val(tag, 32'(dut.state_reg), 32'(s));
  endtask

  // Frame monitor: every swap pops one expected frame from the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b1 && io.frame_ready === 1'b1) begin
      fr_count++;
      check_val("frame_ready_width", fr_prev, 0);
      if (exp_trig_q.size() == 0) begin
        check_val("unexpected_frame", 1, 0);
      end else begin
        exp_t = exp_trig_q.pop_front();
        check_val("triggered", io.triggered, exp_t);
        for (int i = 0; i < SAMPLES; i++) begin
          if (exp_q.size() == 0) begin
            check_val("scoreboard_underrun", 1, 0);
            break;
          end
          check_val($sformatf("data_display[%0d]", i), io.data_display[i], exp_q.pop_front());
        end
        $display("[TB] frame %0d swapped in, triggered=%0d data[0]=0x%0h data[255]=0x%0h",
                 fr_count, io.triggered, io.data_display[0], io.data_display[SAMPLES-1]);
      end
    end
    fr_prev = io.frame_ready;
  end

  initial begin
    rst             = 1'b0;
    io.sample_valid = 1'b0;
    io.sample       = '0;
    io.trig_level   = 12'h800;
    io.trig_falling = 1'b0;
    io.auto_mode    = 1'b0;
    io.decim        = 8'd0;
    io.freeze       = 1'b0;
    io.vblnk        = 1'b0;

    // Reset with random activity on every input
    repeat (5) begin
      @(posedge clk);
      #1;
      io.sample_valid = 1'($urandom_range(0, 1));
      io.sample       = 12'($urandom);
      io.vblnk        = 1'($urandom_range(0, 1));
      io.freeze       = 1'($urandom_range(0, 1));
      io.auto_mode    = 1'($urandom_range(0, 1));
      io.trig_falling = 1'($urandom_range(0, 1));
      io.decim        = 8'($urandom);
    end
    @(negedge clk);
    nz = 0;
    for (int i = 0; i < SAMPLES; i++) if (io.data_display[i] != 0) nz++;
    check_val("reset_data_nonzero", nz, 0);
    check_val("reset_frame_ready", io.frame_ready, 0);
    check_val("reset_triggered", io.triggered, 0);
    check_state("reset_state", IDLE);
    @(posedge clk);
    #1;
    rst             = 1'b1;
    io.sample_valid = 1'b0;
    io.vblnk        = 1'b0;
    io.freeze       = 1'b0;
    io.auto_mode    = 1'b0;
    io.trig_falling = 1'b0;
    io.trig_level   = 12'h800;
    io.decim        = 8'd0;
    @(negedge clk);
    check_state("release_idle", IDLE);
    @(posedge clk);
    #1;
    check_state("release_wait_trig", WAIT_TRIG);

    // Rising trigger on a ramp crossing 0x800
    exp_trig_q.push_back(1'b1);
    strobe('h7F0, 0);
    strobe('h7F8, 0);
    for (int k = 0; k < 256; k++) strobe('h800 + 8 * k, 1);
    strobe('h800 + 8 * 256, 0);
    check_val("rise_no_frame_before_blank", fr_count, 0);
    blank_pulse();
    expect_frames(1);
    tick(3);
    check_val("rise_single_pulse", fr_count, 1);

    // Falling trigger with decimation by 4; crossing on strobe 9, capture from strobe 12
    io.trig_falling = 1'b1;
    io.trig_level   = 12'h400;
    io.decim        = 8'd3;
    exp_trig_q.push_back(1'b1);
    for (int i = 0; i < 1036; i++)
      strobe((i < 9) ? ('h600 + i) : ('h100 + i), (i >= 12) && ((i - 12) % 4 == 0) && ((i - 12) / 4 < 256));
    blank_pulse();
    expect_frames(2);

    // Auto timeout: the 16th accept becomes index 0
    io.trig_falling = 1'b0;
    io.trig_level   = 12'h800;
    io.decim        = 8'd0;
    io.auto_mode    = 1'b1;
    exp_trig_q.push_back(1'b0);
    for (int i = 0; i < 15; i++) strobe('h100, 0);
    check_state("auto_wait_after_15", WAIT_TRIG);
    strobe('h100, 1);
    check_state("auto_capture_at_16", CAPTURE);
    for (int i = 0; i < 255; i++) strobe('h100, 1);
    check_state("auto_done", DONE);
    blank_pulse();
    expect_frames(3);

    io.auto_mode = 1'b0;
    repeat (10000) strobe('h100, 0);
    check_state("no_auto_capture", WAIT_TRIG);
    blank_pulse();
    tick(2);
    check_val("no_auto_frame", fr_count, 3);

    // Freeze holds the front frame across several blanks
    io.freeze = 1'b1;
    exp_trig_q.push_back(1'b1);
    strobe('h100, 0);
    for (int k = 0; k < 256; k++) strobe('h900 + k, 1);
    check_state("freeze_done", DONE);
    repeat (3) strobe('hAAA, 0);
    repeat (3) blank_pulse();
    check_val("freeze_no_swap", fr_count, 3);
    check_val("freeze_front_kept", io.data_display[0], 'h100);
    io.freeze = 1'b0;
    blank_pulse();
    expect_frames(4);

    // Blank edge coincident with the index-255 write does not swap
    exp_trig_q.push_back(1'b1);
    strobe('h100, 0);
    for (int k = 0; k < 255; k++) strobe('h900 + 2 * k, 1);
    io.vblnk = 1'b1;
    strobe('h900 + 2 * 255, 1);
    tick(3);
    check_val("edge_on_last_write_no_swap", fr_count, 4);
    check_state("edge_on_last_write_done", DONE);
    io.vblnk = 1'b0;
    tick(2);
    blank_pulse();
    expect_frames(5);

    check_val("scoreboard_empty", exp_q.size(), 0);
    check_val("trig_queue_empty", exp_trig_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
